fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 145 ++++++++++++++
 tb/tb_fetch_unit.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch front end: one outstanding imem request, 2-entry
// {instr, pc} buffer toward decode, and redirect-driven flush/drop.
module fetch_unit #(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic                  imem_rvalid,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    input  logic                  redirect,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [DATA_WIDTH-1:0] pc,
    output logic                  instr_valid,
    input  logic                  id_ready
);

    localparam int unsigned           CNT_W      = 2;
    localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = ~DATA_WIDTH'(3);
    localparam logic [DATA_WIDTH-1:0] PC_STEP    = DATA_WIDTH'(4);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DROP
    } state_e;

    state_e                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   fetch_pc_q, fetch_pc_d;
    logic [DATA_WIDTH-1:0]   req_addr_q, req_addr_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [DATA_WIDTH-1:0]   fifo_instr_q [2];
    logic [DATA_WIDTH-1:0]   fifo_instr_d [2];
    logic [DATA_WIDTH-1:0]   fifo_pc_q    [2];
    logic [DATA_WIDTH-1:0]   fifo_pc_d    [2];

    logic                    req_c;
    logic                    push_c;
    logic                    pop_c;
    logic [CNT_W-1:0]        occ_pop_c;

    // Request address is the word-aligned fetch pointer; reset gates the request
    assign imem_addr   = fetch_pc_q & ALIGN_MASK;
    assign imem_req    = req_c & ~rst;

    // FIFO head toward decode, zero when empty
    assign instr_valid = (count_q != CNT_W'(0));
    assign instr       = instr_valid ? fifo_instr_q[0] : '0;
    assign pc          = instr_valid ? fifo_pc_q[0]    : '0;

    // Next-state, request issue and FIFO push/pop/flush
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_addr_d = req_addr_q;
        for (int i = 0; i < 2; i++) begin
            fifo_instr_d[i] = fifo_instr_q[i];
            fifo_pc_d[i]    = fifo_pc_q[i];
        end
        req_c     = 1'b0;
        push_c    = 1'b0;
        pop_c     = instr_valid && id_ready && !redirect;
        occ_pop_c = count_q - CNT_W'(pop_c);

        case (state_q)
            S_IDLE: begin
                if (!redirect && occ_pop_c <= CNT_W'(1)) begin
                    req_c   = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    push_c = !redirect;
                    if (!redirect && (occ_pop_c + CNT_W'(push_c)) <= CNT_W'(1)) begin
                        req_c   = 1'b1;
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (redirect) begin
                    state_d = S_DROP;
                end
            end
            S_DROP: begin
                if (imem_rvalid) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Pop shifts the second entry into the head slot
        if (pop_c) begin
            fifo_instr_d[0] = fifo_instr_q[1];
            fifo_pc_d[0]    = fifo_pc_q[1];
        end

        // Push lands in the first free slot after this cycle's pop
        if (push_c) begin
            fifo_instr_d[occ_pop_c[0]] = imem_rdata;
            fifo_pc_d[occ_pop_c[0]]    = req_addr_q;
        end

        count_d = occ_pop_c + CNT_W'(push_c);

        if (req_c) begin
            fetch_pc_d = fetch_pc_q + PC_STEP;
            req_addr_d = imem_addr;
        end

        // Redirect flushes everything queued and retargets fetch
        if (redirect) begin
            count_d    = '0;
            fetch_pc_d = redirect_pc & ALIGN_MASK;
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            req_addr_q <= '0;
            count_q    <= '0;
            for (int i = 0; i < 2; i++) begin
                fifo_instr_q[i] <= '0;
                fifo_pc_q[i]    <= '0;
            end
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_addr_q <= req_addr_d;
            count_q    <= count_d;
            for (int i = 0; i < 2; i++) begin
                fifo_instr_q[i] <= fifo_instr_d[i];
                fifo_pc_q[i]    <= fifo_pc_d[i];
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a small in-order imem model of
// configurable latency; all expected values are hand-derived constants.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        instr_valid;
    logic        id_ready;

    int n_cmp = 0;
    int n_err = 0;

    // imem model state
    int          lat;
    int          cd;
    logic        pend;
    logic [31:0] pend_addr;

    // outputs sampled mid-cycle
    logic        s_req;
    logic [31:0] s_addr;
    logic        s_valid;
    logic [31:0] s_pc;
    logic [31:0] s_instr;

    fetch_unit #(.DATA_WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr       (instr),
        .pc          (pc),
        .instr_valid (instr_valid),
        .id_ready    (id_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_5A5A;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: apply inputs after the edge, let imem answer, sample outputs
    task automatic step(input logic r, input logic rdy, input logic redir, input logic [31:0] rpc);
        @(posedge clk);
        #1;
        rst         = r;
        id_ready    = rdy;
        redirect    = redir;
        redirect_pc = rpc;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        if (r) begin
            pend = 1'b0;
        end else if (pend) begin
            if (cd == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(pend_addr);
                pend        = 1'b0;
            end else begin
                cd--;
            end
        end
        #1;
        s_req   = imem_req;
        s_addr  = imem_addr;
        s_valid = instr_valid;
        s_pc    = pc;
        s_instr = instr;
        if (s_req && !r) begin
            pend      = 1'b1;
            pend_addr = s_addr;
            cd        = lat - 1;
        end
    endtask

    task automatic do_reset();
        step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
    endtask

    initial begin
        rst = 1'b1; id_ready = 1'b1; redirect = 1'b0; redirect_pc = '0;
        imem_rvalid = 1'b0; imem_rdata = '0;
        pend = 1'b0; pend_addr = '0; cd = 0; lat = 1;

        // Reset values and streaming with 1-cycle memory
        do_reset();
        check("rst_req",   32'(s_req),   32'd0);
        check("rst_valid", 32'(s_valid), 32'd0);
        check("rst_pc",    s_pc,         32'h0);
        check("rst_instr", s_instr,      32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        check("s1_c0_req",   32'(s_req),   32'd1);
        check("s1_c0_addr",  s_addr,       32'h0);
        check("s1_c0_valid", 32'(s_valid), 32'd0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        check("s1_c1_addr",  s_addr,       32'h4);
        check("s1_c1_valid", 32'(s_valid), 32'd0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        check("s1_c2_addr",  s_addr,       32'h8);
        check("s1_c2_valid", 32'(s_valid), 32'd1);
        check("s1_c2_pc",    s_pc,         32'h0);
        check("s1_c2_instr", s_instr,      32'hA5A5_5A5A);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        check("s1_c3_addr",  s_addr,       32'hC);
        check("s1_c3_pc",    s_pc,         32'h4);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        check("s1_c4_pc",    s_pc,         32'h8);
        check("s1_c4_instr", s_instr,      32'hA5A5_5A52);

        // Decoder stalled: buffer fills to 2, requests stop, order kept
        do_reset();
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("s2_c1_req",  32'(s_req), 32'd1);
        check("s2_c1_addr", s_addr,     32'h4);
        for (int i = 2; i < 6; i++) begin
            step(1'b0, 1'b0, 1'b0, 32'h0);
            check($sformatf("s2_c%0d_req", i), 32'(s_req), 32'd0);
            if (i >= 3) begin
                check($sformatf("s2_c%0d_pc", i), s_pc, 32'h0);
            end
        end
        check("s2_c5_valid", 32'(s_valid), 32'd1);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        check("s2_c6_req",  32'(s_req), 32'd1);
        check("s2_c6_addr", s_addr,     32'h8);
        check("s2_c6_pc",   s_pc,       32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        check("s2_c7_pc",   s_pc,       32'h4);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        check("s2_c8_pc",    s_pc,    32'h8);
        check("s2_c8_instr", s_instr, 32'hA5A5_5A52);

        // Redirect while waiting on a 2-cycle memory: late response dropped
        lat = 2;
        do_reset();
        step(1'b0, 1'b1, 1'b0, 32'h0);
        check("s3_c0_addr", s_addr, 32'h0);
        step(1'b0, 1'b1, 1'b1, 32'h100);
        check("s3_c1_req", 32'(s_req), 32'd0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        check("s3_c2_req",   32'(s_req),   32'd0);
        check("s3_c2_valid", 32'(s_valid), 32'd0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        check("s3_c3_req",   32'(s_req),   32'd1);
        check("s3_c3_addr",  s_addr,       32'h100);
        check("s3_c3_valid", 32'(s_valid), 32'd0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        check("s3_c5_valid", 32'(s_valid), 32'd0);
        check("s3_c5_addr",  s_addr,       32'h104);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        check("s3_c6_valid", 32'(s_valid), 32'd1);
        check("s3_c6_pc",    s_pc,         32'h100);
        check("s3_c6_instr", s_instr,      32'hA5A5_5B5A);

        // Redirect to unaligned target coincident with the response
        lat = 1;
        do_reset();
        step(1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b1, 32'h203);
        check("s4_c1_req", 32'(s_req), 32'd0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        check("s4_c2_req",   32'(s_req),   32'd1);
        check("s4_c2_addr",  s_addr,       32'h200);
        check("s4_c2_valid", 32'(s_valid), 32'd0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        check("s4_c3_addr", s_addr, 32'h204);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        check("s4_c4_pc",    s_pc,    32'h200);
        check("s4_c4_instr", s_instr, 32'hA5A5_585A);

        // Fetch pointer wraps from the top of the address space
        do_reset();
        step(1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        check("s5_c2_addr", s_addr, 32'hFFFF_FFFC);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        check("s5_c3_addr", s_addr, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        check("s5_c4_pc",    s_pc,    32'hFFFF_FFFC);
        check("s5_c4_instr", s_instr, 32'h5A5A_A5A6);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        check("s5_c5_pc", s_pc, 32'h0);

        // Reset with a full buffer
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
        check("s6_full_valid", 32'(s_valid), 32'd1);
        step(1'b1, 1'b0, 1'b1, 32'h400);
        check("s6_rst_req", 32'(s_req), 32'd0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        check("s6_post_valid", 32'(s_valid), 32'd0);
        check("s6_post_req",   32'(s_req),   32'd1);
        check("s6_post_addr",  s_addr,       32'h0);

        // Reset with an entry buffered and a request outstanding (3-cycle memory)
        lat = 3;
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
        check("s7_c3_req",  32'(s_req), 32'd1);
        check("s7_c3_addr", s_addr,     32'h4);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        check("s7_rst_req", 32'(s_req), 32'd0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        check("s7_post_valid", 32'(s_valid), 32'd0);
        check("s7_post_req",   32'(s_req),   32'd1);
        check("s7_post_addr",  s_addr,       32'h0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 32'h0);
        check("s7_late_valid", 32'(s_valid), 32'd1);
        check("s7_late_pc",    s_pc,         32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
